output_store_controller: RTL
============================

// Module: output_store_controller
// PURPOSE
//   Sequences the output_block chain behind systolic_array: clears the stage, shifts mux-select config into
//   the sel_mux_out chain, then drives per-pixel register capture and BRAM read-modify-write addressing
//   across n weight rounds. Sits beside SA_controller; its outputs drive the shared output_block control nets.
// PARAMETERS
//   BRAM_ADDR_WIDTH      15  output-pixel address width
//   COUNTER_ROUND_WIDTH  3   round counter width
//   SEL_LD_CYCLES        16  sel_mux_out_ld cycles to fill the select chain (= N_COLS_ARRAY)
//   RMW_LATENCY          2   cycles from BRAM read address to write-back of the summed value
// PORTS
//   clk_i                   in   1    clock, rising edge
//   general_rst_ni          in   1    async active-low reset
//   start_i                 in   1    1-cycle pulse, begin a layer
//   n_outputs_i             in   BAW  output pixels per round, latched at start
//   max_round_i             in   CRW  number of weight rounds, latched at start (0 treated as 1)
//   result_valid_i          in   1    one pulse per output pixel from the array
//   mux_out_reg_rst_o       out  1    output register reset
//   mux_out_reg_wr_en_o     out  1    capture result_o into the output register
//   sel_mux_out_rst_o       out  1    select-chain reset
//   sel_mux_out_ld_o        out  1    select-chain shift enable
//   bram_rst_o              out  1    BRAM output reset
//   bram_wr_en_a_o          out  1    port A write (write-back)
//   bram_wr_en_b_o          out  1    port B write, held 0 (port B is read-only here)
//   bram_addr_write_read_o  out  BAW  port A address
//   bram_addr_read_write_o  out  BAW  port B address
//   accum_en_o              out  1    1 = add BRAM partial sum, 0 = overwrite (round 0)
//   busy_o / done_o / err_o out  1    active / 1-cycle completion pulse / sticky error
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-operation aborts immediately; no done_o.
//   FSM IDLE->CLR->SEL->ACC->DRAIN->DONE->IDLE; busy_o=1 in every state except IDLE.
//   IDLE: on start_i, latch config. If n_outputs_i < RMW_LATENCY+1, set err_o and stay IDLE; otherwise
//     go to CLR. start_i while busy is ignored.
//   CLR: 1 cycle; mux_out_reg_rst_o, sel_mux_out_rst_o and bram_rst_o are all 1.
//   SEL: sel_mux_out_ld_o=1 for exactly SEL_LD_CYCLES cycles, then ACC.
//   ACC: pixel counter p (0..n-1) and round counter r (0..max-1). For result_valid_i at cycle t:
//     t: mux_out_reg_wr_en_o=1.
//     t+1: bram_addr_read_write_o=p.
//     t+1+RMW_LATENCY: bram_wr_en_a_o=1 and bram_addr_write_read_o=p; accum_en_o=(r!=0) aligned to this write.
//     The pipeline is shift-register based, so back-to-back pulses are accepted every cycle.
//     p wraps n-1->0 with r+1. After the last pixel of the last round, go to DRAIN.
//   DRAIN: wait until the write pipeline is empty (RMW_LATENCY+1 cycles), then DONE.
//     result_valid_i arriving here is dropped and sets err_o.
//   DONE: done_o=1 for 1 cycle, then IDLE.
//   result_valid_i outside ACC sets err_o. err_o clears only on reset or on the next accepted start_i.
//   Addresses hold their last value when idle; bram_wr_en_b_o is always 0.
// TESTING
//   reset low mid-ACC -> all outputs 0 on the same edge, IDLE, busy_o=0, done_o never pulses.
//   start_i, n=4, max=1 -> 1 CLR cycle, 16 SEL cycles; 4 back-to-back valids give writes at p=0..3,
//     3 cycles after each valid, with accum_en_o=0; done_o pulses once.
//   n=3, max=2, back-to-back valids -> round-1 writes carry accum_en_o=1; read of p=0 in round 1
//     occurs after the round-0 write of p=0.
//   start_i with n=2 (< RMW_LATENCY+1) -> err_o=1, busy_o stays 0.
//   result_valid_i during SEL, and start_i during ACC -> err_o=1 for the valid, start ignored,
//     p/r counters unchanged.

Source files
------------

// File: rtl/output_store_controller.sv
// Control sequencer for the output_block chain: clear, load the select chain, then capture
// each pixel and steer BRAM read-modify-write addressing over all weight rounds.
module output_store_controller #(
  parameter int BRAM_ADDR_WIDTH     = 15,
  parameter int COUNTER_ROUND_WIDTH = 3,
  parameter int SEL_LD_CYCLES       = 16,
  parameter int RMW_LATENCY         = 2
) (
  input  logic                           clk_i,
  input  logic                           general_rst_ni,
  input  logic                           start_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]     n_outputs_i,
  input  logic [COUNTER_ROUND_WIDTH-1:0] max_round_i,
  input  logic                           result_valid_i,
  output logic                           mux_out_reg_rst_o,
  output logic                           mux_out_reg_wr_en_o,
  output logic                           sel_mux_out_rst_o,
  output logic                           sel_mux_out_ld_o,
  output logic                           bram_rst_o,
  output logic                           bram_wr_en_a_o,
  output logic                           bram_wr_en_b_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_write_read_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_read_write_o,
  output logic                           accum_en_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);
  localparam int BAW    = BRAM_ADDR_WIDTH;
  localparam int CRW    = COUNTER_ROUND_WIDTH;
  localparam int STAGES = RMW_LATENCY;
  localparam int SCW    = $clog2(SEL_LD_CYCLES + 1);
  localparam logic [BAW-1:0] MIN_N = BAW'(RMW_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SEL, S_ACC, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [BAW-1:0]           n_q, p_q, rd_addr_q, wr_addr_q;
  logic [CRW-1:0]           max_q, r_q;
  logic [SCW-1:0]           sel_cnt_q;
  logic [STAGES:0]          vld_pipe, acc_pipe;
  logic [STAGES-1:0][BAW-1:0] p_pipe;
  logic                     err_q;
  logic                     start_acc, start_bad, start_ok, fire, last_px, last_rd, stray;

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign start_bad = start_acc && (n_outputs_i < MIN_N);
  assign start_ok  = start_acc && !start_bad;
  assign fire      = (state_q == S_ACC) && result_valid_i;
  assign stray     = result_valid_i && (state_q != S_ACC);
  assign last_px   = (p_q == n_q - BAW'(1));
  assign last_rd   = (r_q == max_q - CRW'(1));

  always_ff @(posedge clk_i or negedge general_rst_ni) begin
    if (!general_rst_ni) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    mux_out_reg_rst_o   = 1'b0;
    sel_mux_out_rst_o   = 1'b0;
    bram_rst_o          = 1'b0;
    sel_mux_out_ld_o    = 1'b0;
    done_o              = 1'b0;
    busy_o              = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_CLR;
      S_CLR: begin
        mux_out_reg_rst_o = 1'b1;
        sel_mux_out_rst_o = 1'b1;
        bram_rst_o        = 1'b1;
        state_d           = S_SEL;
      end
      S_SEL: begin
        sel_mux_out_ld_o = 1'b1;
        if (sel_cnt_q == SCW'(SEL_LD_CYCLES - 1)) state_d = S_ACC;
      end
      S_ACC:   if (fire && last_px && last_rd) state_d = S_DRAIN;
      // Only the write stage may still be busy; it completes this cycle.
      S_DRAIN: if (vld_pipe[STAGES-1:0] == '0) state_d = S_DONE;
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge general_rst_ni) begin
    if (!general_rst_ni) begin
      n_q       <= '0;
      max_q     <= '0;
      p_q       <= '0;
      r_q       <= '0;
      sel_cnt_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      vld_pipe  <= '0;
      acc_pipe  <= '0;
      p_pipe    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (start_acc) begin
        n_q   <= n_outputs_i;
        max_q <= (max_round_i == '0) ? CRW'(1) : max_round_i;
      end
      if (start_ok) begin
        p_q <= '0;
        r_q <= '0;
      end else if (fire) begin
        rd_addr_q <= p_q;
        if (last_px) begin
          p_q <= '0;
          r_q <= r_q + CRW'(1);
        end else begin
          p_q <= p_q + BAW'(1);
        end
      end
      if (state_q == S_CLR)      sel_cnt_q <= '0;
      else if (state_q == S_SEL) sel_cnt_q <= sel_cnt_q + SCW'(1);
      // Write-back pipe: stage k is live k+1 cycles after the captured pulse.
      vld_pipe  <= {vld_pipe[STAGES-1:0], fire};
      acc_pipe  <= {acc_pipe[STAGES-1:0], fire && (r_q != '0)};
      p_pipe[0] <= p_q;
      for (int i = 1; i < STAGES; i++) p_pipe[i] <= p_pipe[i-1];
      if (vld_pipe[STAGES-1]) wr_addr_q <= p_pipe[STAGES-1];
      if (stray || start_bad) err_q <= 1'b1;
      else if (start_ok)      err_q <= 1'b0;
    end
  end

  assign mux_out_reg_wr_en_o    = fire;
  assign bram_wr_en_a_o         = vld_pipe[STAGES];
  assign bram_wr_en_b_o         = 1'b0;
  assign accum_en_o             = acc_pipe[STAGES];
  assign bram_addr_read_write_o = rd_addr_q;
  assign bram_addr_write_read_o = wr_addr_q;
  assign err_o                  = err_q;
endmodule
